// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: walks start/data/parity/stop bits, strobes the
// checkers and deserializer at the sample point, and qualifies the received byte.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   input  logic       PAR_EN,
   input  logic [5:0] Prescale,
   input  logic [4:0] edge_cnt,
   input  logic [3:0] bit_cnt,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_err,
   output logic       cnt_en,
   output logic       samp_en,
   output logic       strt_chk_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       deser_en,
   output logic       data_valid,
   output logic       par_error,
   output logic       frm_error
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, VALID} state_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

   state_t     state, next_state;
   logic [5:0] mid, edge_ext;
   logic       sample_done, bit_end, frame_start;
   logic       par_en_q, par_flag;

   // Majority vote uses MID-1..MID+1, so the sampled bit is settled two edges past MID.
   assign mid         = Prescale >> 1;
   assign edge_ext    = {1'b0, edge_cnt};
   assign sample_done = (edge_ext == mid + 6'd2);
   assign bit_end     = (edge_ext == Prescale - 6'd1);
   assign frame_start = ((state == IDLE) || (state == VALID)) && !rx_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (!rx_in) next_state = START;
         START:  if (bit_end) next_state = strt_glitch ? IDLE : DATA;
         DATA:   if (bit_end && (bit_cnt == LAST_BIT)) next_state = par_en_q ? PARITY : STOP;
         PARITY: if (bit_end) next_state = STOP;
         STOP:   if (bit_end) next_state = VALID;
         VALID:  next_state = rx_in ? IDLE : START;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cnt_en      = 1'b0;
      samp_en     = 1'b0;
      strt_chk_en = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      deser_en    = 1'b0;
      case (state)
         START: begin
            cnt_en      = 1'b1;
            samp_en     = 1'b1;
            strt_chk_en = sample_done;
         end
         DATA: begin
            cnt_en   = 1'b1;
            samp_en  = 1'b1;
            deser_en = sample_done;
         end
         PARITY: begin
            cnt_en     = 1'b1;
            samp_en    = 1'b1;
            par_chk_en = sample_done;
         end
         STOP: begin
            cnt_en     = 1'b1;
            samp_en    = 1'b1;
            stp_chk_en = sample_done;
         end
         default: ;
      endcase
   end

   // Frame-level flags: error flags stay visible until the next start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_valid <= 1'b0;
         par_error  <= 1'b0;
         frm_error  <= 1'b0;
         par_en_q   <= 1'b0;
         par_flag   <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (frame_start) begin
            par_en_q  <= PAR_EN;
            par_flag  <= 1'b0;
            par_error <= 1'b0;
            frm_error <= 1'b0;
         end
         if ((state == PARITY) && bit_end) par_flag <= par_err;
         if ((state == STOP) && bit_end) begin
            par_error  <= par_flag;
            frm_error  <= stp_err;
            data_valid <= !par_flag && !stp_err;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models counter, oversampler, checkers and deserializer
// around the FSM; a monitor scores each frame end against queued expectations.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_in = 1'b1;
   logic       PAR_EN = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [4:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       strt_glitch, par_err, stp_err;
   logic       cnt_en, samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
   logic       data_valid, par_error, frm_error;

   typedef struct {
      logic [7:0] data;
      logic       par_on;
      logic       dv;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0;
   int   n_deser = 0, n_par = 0, n_stp = 0, tot_deser = 0, tot_dv = 0;
   logic samp = 1'b1, fe_prev = 1'b0;
   logic [7:0] sh;

   uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .PAR_EN(PAR_EN), .Prescale(Prescale),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
      .par_err(par_err), .stp_err(stp_err), .cnt_en(cnt_en), .samp_en(samp_en),
      .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
      .deser_en(deser_en), .data_valid(data_valid), .par_error(par_error),
      .frm_error(frm_error)
   );

   always #5 clk = ~clk;

   // Surrounding RX datapath: edge/bit counter, sampler, checkers, deserializer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0; bit_cnt <= '0; samp <= 1'b1; sh <= '0;
         strt_glitch <= 1'b0; par_err <= 1'b0; stp_err <= 1'b0;
      end else begin
         if (!cnt_en) begin
            edge_cnt <= '0; bit_cnt <= '0;
         end else if ({1'b0, edge_cnt} == Prescale - 6'd1) begin
            edge_cnt <= '0; bit_cnt <= bit_cnt + 4'd1;
         end else edge_cnt <= edge_cnt + 5'd1;
         if (samp_en && ({1'b0, edge_cnt} == (Prescale >> 1))) samp <= rx_in;
         if (strt_chk_en) strt_glitch <= samp;
         if (par_chk_en)  par_err <= (^sh) ^ samp;
         if (stp_chk_en)  stp_err <= ~samp;
         if (deser_en)    sh <= {samp, sh[7:1]};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: strobe placement plus per-frame scoreboard at the frame-end edge.
   always @(negedge clk) begin
      int   mid2;
      logic fe_now;
      exp_t e;
      if (!rst_n) fe_prev = 1'b0;
      else begin
         mid2 = int'(Prescale >> 1) + 2;
         if (strt_chk_en) begin
            n_deser = 0; n_par = 0; n_stp = 0;
            chk("strt_edge", 32'(edge_cnt), 32'(mid2));
         end
         if (deser_en) begin
            n_deser++; tot_deser++;
            chk("deser_edge", 32'(edge_cnt), 32'(mid2));
         end
         if (par_chk_en) begin
            n_par++;
            chk("par_edge", 32'(edge_cnt), 32'(mid2));
         end
         if (stp_chk_en) begin
            n_stp++;
            chk("stp_edge", 32'(edge_cnt), 32'(mid2));
         end
         if (data_valid) tot_dv++;
         fe_now = data_valid | par_error | frm_error;
         if (fe_now && !fe_prev) begin
            if (q.size() == 0) chk("unexpected_frame", 32'(q.size()), 32'd1);
            else begin
               e = q.pop_front();
               chk("data_valid", 32'(data_valid), 32'(e.dv));
               chk("par_error", 32'(par_error), 32'(e.pe));
               chk("frm_error", 32'(frm_error), 32'(e.fe));
               chk("data_byte", 32'(sh), 32'(e.data));
               chk("deser_count", 32'(n_deser), 32'd8);
               chk("par_chk_count", 32'(n_par), 32'(e.par_on));
               chk("stp_chk_count", 32'(n_stp), 32'd1);
               chk("cnt_clear_at_end", 32'(cnt_en), 32'd0);
            end
         end
         fe_prev = fe_now;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one frame aligned to the FSM; returns just after the stop-bit end edge.
   task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bad,
                             input logic stop_bit, input logic toggle,
                             input logic exp_dv, input logic exp_pe, input logic exp_fe);
      exp_t e;
      int   p;
      e.data = d; e.par_on = par_on; e.dv = exp_dv; e.pe = exp_pe; e.fe = exp_fe;
      q.push_back(e);
      p = int'(Prescale);
      PAR_EN = par_on;
      rx_in  = 1'b0;
      wait_clks(1);
      chk("err_clear_at_start", 32'({par_error, frm_error}), 32'd0);
      wait_clks(p);
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         if (toggle && (i == 3)) PAR_EN = ~PAR_EN;
         wait_clks(p);
      end
      if (par_on) begin
         rx_in = (^d) ^ par_bad;
         wait_clks(p);
      end
      rx_in = stop_bit;
      wait_clks(p);
      rx_in = 1'b1;
   endtask

   initial begin
      int d0, v0;
      #12;
      chk("reset_outputs", 32'({cnt_en, samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                               deser_en, data_valid, par_error, frm_error}), 32'd0);
      wait_clks(1);
      rst_n = 1'b1;
      wait_clks(4);

      // 1: Prescale 8, no parity, 0x5A
      Prescale = 6'd8;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_clks(1);
      chk("dv_one_cycle", 32'(data_valid), 32'd0);
      wait_clks(5);

      // 2: Prescale 16, even parity good, then inverted parity bit
      Prescale = 6'd16;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_clks(5);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_clks(5);

      // 3: short start glitch
      Prescale = 6'd8;
      d0 = tot_deser; v0 = tot_dv;
      rx_in = 1'b0;
      wait_clks(3);
      rx_in = 1'b1;
      wait_clks(16);
      chk("glitch_no_deser", 32'(tot_deser), 32'(d0));
      chk("glitch_no_dv", 32'(tot_dv), 32'(v0));
      chk("glitch_no_flags", 32'({par_error, frm_error}), 32'd0);
      chk("glitch_back_idle", 32'({cnt_en, samp_en}), 32'd0);

      // 4: stop bit low -> framing error held until next start, then a clean frame
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_clks(20);
      chk("frm_error_held", 32'(frm_error), 32'd1);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_clks(5);

      // 5: back-to-back frames at Prescale 32
      Prescale = 6'd32;
      send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(8'hED, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_clks(5);

      // 6: reset during data bit 4, then PAR_EN toggled mid-frame
      Prescale = 6'd8;
      rx_in = 1'b0;
      wait_clks(9);
      for (int i = 0; i < 3; i++) begin
         rx_in = i[0];
         wait_clks(8);
      end
      wait_clks(3);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({cnt_en, samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                                     deser_en, data_valid, par_error, frm_error}), 32'd0);
      rx_in = 1'b1;
      wait_clks(2);
      rst_n = 1'b1;
      wait_clks(20);
      chk("idle_after_reset", 32'({cnt_en, samp_en, data_valid}), 32'd0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_clks(5);
      send_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_clks(10);

      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-sequencing FSM for the UART receiver. It enables the edge/bit counter and the oversampler, and issues one-cycle strobes to the start/parity/stop checkers and the deserializer at the correct edge of each bit. It qualifies the received byte with data_valid. It sits between rx_in and the RX datapath sub-blocks, in the RX clock domain.

Parameters:
DATA_WIDTH, 8, data bits per frame; bit_cnt value of the last data bit.

Ports:
clk  in  1  RX oversampling clock
rst_n  in  1  asynchronous active-low reset
rx_in  in  1  serial line, idle high
PAR_EN  in  1  1 = parity bit present
Prescale  in  6  oversampling ratio; legal values 8, 16, 32; static while not idle
edge_cnt  in  5  from counter; 0..Prescale-1 within a bit
bit_cnt  in  4  from counter; 0 = start, 1..DATA_WIDTH = data, then parity (if enabled), then stop
strt_glitch  in  1  start checker result, registered, valid the cycle after strt_chk_en
par_err  in  1  parity checker result, registered, valid the cycle after par_chk_en
stp_err  in  1  stop checker result, registered, valid the cycle after stp_chk_en
cnt_en  out  1  counter enable; counter clears to 0 when low
samp_en  out  1  oversampler enable
strt_chk_en  out  1  one-cycle start-check strobe
par_chk_en  out  1  one-cycle parity-check strobe
stp_chk_en  out  1  one-cycle stop-check strobe
deser_en  out  1  one-cycle shift strobe per data bit
data_valid  out  1  registered; one-cycle pulse per good frame
par_error  out  1  registered; set with the frame-end cycle, held until next frame start
frm_error  out  1  registered; same timing as par_error, for stop-bit error

Behaviour:
- Reset (async, any state): state = IDLE; data_valid, par_error, frm_error = 0; latched parity enable = 0. All combinational outputs are 0 in IDLE.
- Definitions:
  - MID = Prescale>>1.
  - SAMPLE_DONE is true when edge_cnt == MID+2. The oversampler majority-votes edges MID-1, MID, MID+1, so the sampled bit is stable at MID+2.
  - BIT_END is true when edge_cnt == Prescale-1.
- States: IDLE, START, DATA, PARITY, STOP, VALID. Encoding is free; state is registered.
- IDLE: cnt_en = 0, samp_en = 0. On rx_in == 0 → START. On the same edge, latch PAR_EN into par_en_q and clear par_error and frm_error.
- START, DATA, PARITY, STOP: cnt_en = 1 and samp_en = 1 in all four.
- START: strt_chk_en = SAMPLE_DONE. At BIT_END: if strt_glitch = 1 → IDLE, with no error flags and no data_valid; else → DATA.
- DATA: deser_en = SAMPLE_DONE. At BIT_END with bit_cnt == DATA_WIDTH: → PARITY if par_en_q, else → STOP.
- PARITY: par_chk_en = SAMPLE_DONE. At BIT_END → STOP unconditionally. par_err is captured into an internal flag at BIT_END.
- STOP: stp_chk_en = SAMPLE_DONE. At BIT_END → VALID. On the same edge:
  - par_error <= captured parity flag;
  - frm_error <= stp_err;
  - data_valid <= 1 only if both are 0.
- VALID (exactly one cycle): cnt_en = 0, samp_en = 0, so the counter clears. data_valid returns to 0 on the next edge. Exit: rx_in == 0 → START (back-to-back frame; latch PAR_EN, clear errors); else → IDLE.
- PAR_EN changes mid-frame are ignored; only par_en_q is used until the next frame start.
- Strobes are Mealy decodes of registered state and edge_cnt. Each strobe fires exactly once per bit, with no glitch at state-entry cycles.
- Width rules:
  - MID+2 and Prescale-1 are computed at 6 bits and compared against zero-extended edge_cnt.
  - Prescale = 32 gives BIT_END at edge_cnt == 31, which is legal.
- Frame lengths: the total is 10 bits without parity and 11 with parity. Worst-case data_valid latency is 1 cycle after the stop-bit BIT_END.

Test Plan:
1. Prescale = 8, PAR_EN = 0, byte 0x5A, clean stop → deser_en fires 8 times at edge_cnt 6; data_valid pulses 1 cycle after stop BIT_END; par_error = 0, frm_error = 0.
2. Prescale = 16, PAR_EN = 1, byte 0xA5 with correct parity → par_chk_en fires once at edge_cnt 10 of bit 9; data_valid = 1. Repeat with the parity bit inverted → par_error = 1, data_valid stays 0.
3. rx_in low for 3 cycles only, Prescale = 8, checker asserts strt_glitch → return to IDLE after edge 7; no deser_en, no data_valid, no error flags.
4. Stop bit driven 0, Prescale = 8 → frm_error = 1, data_valid = 0; flags held until the next start bit, then cleared.
5. Two back-to-back frames, the second start bit immediately after the first stop bit, Prescale = 32 → VALID goes straight to START; both bytes give data_valid; counter clears for 1 cycle between frames.
6. rst_n pulsed low during DATA bit 4 → all outputs 0 immediately; after release with rx_in high, FSM stays in IDLE. Also toggle PAR_EN mid-frame → no effect on the current frame.
